bomb_scheduler: RTL and testbench

BOMB_SCHEDULER -- requirements
Module: bomb_scheduler

---
 rtl/bomb_scheduler.sv | 215 +++++++++++++++++++++
 tb/tb_bomb_scheduler.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/bomb_scheduler.sv
// Bomb slot pool for a two-player grid game. It handles placement arbitration, fuse
// countdown and chain detonation, and presents one explosion at a time to the flame datapath.
module bomb_scheduler #(
    parameter int unsigned NUM_SLOTS  = 8,
    parameter logic [5:0]  FUSE_TICKS = 6'd40
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_tick,
    input  logic         i_p1_place,
    input  logic         i_p2_place,
    input  logic [7:0]   i_p1_cor,
    input  logic [7:0]   i_p2_cor,
    input  logic [2:0]   i_p1_cap,
    input  logic [2:0]   i_p2_cap,
    input  logic [1:0]   i_p1_len,
    input  logic [1:0]   i_p2_len,
    input  logic [255:0] i_explode,
    output logic         o_p1_ack,
    output logic         o_p2_ack,
    output logic         o_exp_valid,
    output logic [7:0]   o_exp_cor,
    output logic [1:0]   o_exp_len,
    output logic         o_exp_owner,
    input  logic         i_exp_ready,
    output logic [2:0]   o_p1_active,
    output logic [2:0]   o_p2_active,
    output logic [255:0] o_bomb_map
);
    localparam int unsigned IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int unsigned CNT_W = $clog2(NUM_SLOTS + 1);

    typedef enum logic {IDLE, PRESENT} state_t;
    state_t state;

    logic [NUM_SLOTS-1:0] live_q, pend_q, owner_q;
    logic [7:0]           cor_q   [NUM_SLOTS];
    logic [1:0]           len_q   [NUM_SLOTS];
    logic [5:0]           timer_q [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] live_d, pend_d, owner_d;
    logic [7:0]           cor_d   [NUM_SLOTS];
    logic [1:0]           len_d   [NUM_SLOTS];
    logic [5:0]           timer_d [NUM_SLOTS];

    logic             prio_q;
    logic [IDX_W-1:0] sel_q;

    logic [CNT_W-1:0] cnt1, cnt2, cnt1_d, cnt2_d;
    logic             hit1, hit2, have0, have1, any_pend;
    logic [IDX_W-1:0] free0, free1, pend_idx, p2_slot;
    logic             e1, e2, conflict, g1, g2, hs;
    logic [255:0]     map_d;

    // Scan the current pool: ownership counts, cell hits, two lowest free slots, lowest pending slot
    always_comb begin
        cnt1 = '0;
        cnt2 = '0;
        hit1 = 1'b0;
        hit2 = 1'b0;
        have0 = 1'b0;
        have1 = 1'b0;
        free0 = '0;
        free1 = '0;
        any_pend = 1'b0;
        pend_idx = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (live_q[i]) begin
                if (owner_q[i]) cnt2 = cnt2 + CNT_W'(1);
                else            cnt1 = cnt1 + CNT_W'(1);
                if (cor_q[i] == i_p1_cor) hit1 = 1'b1;
                if (cor_q[i] == i_p2_cor) hit2 = 1'b1;
            end else if (!have0) begin
                have0 = 1'b1;
                free0 = IDX_W'(i);
            end else if (!have1) begin
                have1 = 1'b1;
                free1 = IDX_W'(i);
            end
            if (pend_q[i] && !any_pend) begin
                any_pend = 1'b1;
                pend_idx = IDX_W'(i);
            end
        end
    end

    // A slot freed by this cycle's handshake is still live here, so a same-cell request is refused
    always_comb begin
        e1 = i_p1_place && (cnt1 < CNT_W'(i_p1_cap)) && !hit1 && have0;
        e2 = i_p2_place && (cnt2 < CNT_W'(i_p2_cap)) && !hit2 && have0;
        conflict = e1 && e2 && ((i_p1_cor == i_p2_cor) || !have1);
        g1 = e1 && (!conflict || !prio_q);
        g2 = e2 && (!conflict || prio_q);
        p2_slot = g1 ? free1 : free0;
        hs = o_exp_valid && i_exp_ready;
    end

    // Next pool state: fuse countdown, chain ignition, release on handshake, new placements
    always_comb begin
        live_d  = live_q;
        pend_d  = pend_q;
        owner_d = owner_q;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            cor_d[i]   = cor_q[i];
            len_d[i]   = len_q[i];
            timer_d[i] = timer_q[i];
        end
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (live_q[i] && !pend_q[i]) begin
                if (i_explode[cor_q[i]]) begin
                    pend_d[i]  = 1'b1;
                    timer_d[i] = '0;
                end else if (i_tick) begin
                    if (timer_q[i] <= 6'd1) begin
                        pend_d[i]  = 1'b1;
                        timer_d[i] = '0;
                    end else begin
                        timer_d[i] = timer_q[i] - 6'd1;
                    end
                end
            end
        end
        if (hs) begin
            live_d[sel_q] = 1'b0;
            pend_d[sel_q] = 1'b0;
        end
        if (g1) begin
            live_d[free0]  = 1'b1;
            pend_d[free0]  = 1'b0;
            owner_d[free0] = 1'b0;
            cor_d[free0]   = i_p1_cor;
            len_d[free0]   = i_p1_len;
            timer_d[free0] = FUSE_TICKS;
        end
        if (g2) begin
            live_d[p2_slot]  = 1'b1;
            pend_d[p2_slot]  = 1'b0;
            owner_d[p2_slot] = 1'b1;
            cor_d[p2_slot]   = i_p2_cor;
            len_d[p2_slot]   = i_p2_len;
            timer_d[p2_slot] = FUSE_TICKS;
        end
        map_d  = '0;
        cnt1_d = '0;
        cnt2_d = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (live_d[i]) begin
                map_d[cor_d[i]] = 1'b1;
                if (owner_d[i]) cnt2_d = cnt2_d + CNT_W'(1);
                else            cnt1_d = cnt1_d + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            live_q      <= '0;
            pend_q      <= '0;
            owner_q     <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                cor_q[i]   <= '0;
                len_q[i]   <= '0;
                timer_q[i] <= '0;
            end
            prio_q      <= 1'b0;
            sel_q       <= '0;
            o_p1_ack    <= 1'b0;
            o_p2_ack    <= 1'b0;
            o_exp_valid <= 1'b0;
            o_exp_cor   <= '0;
            o_exp_len   <= '0;
            o_exp_owner <= 1'b0;
            o_p1_active <= '0;
            o_p2_active <= '0;
            o_bomb_map  <= '0;
        end else begin
            live_q  <= live_d;
            pend_q  <= pend_d;
            owner_q <= owner_d;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                cor_q[i]   <= cor_d[i];
                len_q[i]   <= len_d[i];
                timer_q[i] <= timer_d[i];
            end
            if (conflict) prio_q <= ~prio_q;
            o_p1_ack    <= g1;
            o_p2_ack    <= g2;
            o_p1_active <= 3'(cnt1_d);
            o_p2_active <= 3'(cnt2_d);
            o_bomb_map  <= map_d;
            case (state)
                IDLE: begin
                    if (any_pend) begin
                        state       <= PRESENT;
                        sel_q       <= pend_idx;
                        o_exp_valid <= 1'b1;
                        o_exp_cor   <= cor_q[pend_idx];
                        o_exp_len   <= len_q[pend_idx];
                        o_exp_owner <= owner_q[pend_idx];
                    end
                end
                PRESENT: begin
                    if (i_exp_ready) begin
                        state       <= IDLE;
                        o_exp_valid <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    o_exp_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bomb_scheduler.sv
// Directed bench for bomb_scheduler: placement, fuse expiry, arbitration, chain detonation, full pool, reset.
module tb_bomb_scheduler;
    logic         clk = 1'b0;
    logic         rst;
    logic         i_tick;
    logic         i_p1_place, i_p2_place;
    logic [7:0]   i_p1_cor, i_p2_cor;
    logic [2:0]   i_p1_cap, i_p2_cap;
    logic [1:0]   i_p1_len, i_p2_len;
    logic [255:0] i_explode;
    logic         o_p1_ack, o_p2_ack;
    logic         o_exp_valid;
    logic [7:0]   o_exp_cor;
    logic [1:0]   o_exp_len;
    logic         o_exp_owner;
    logic         i_exp_ready;
    logic [2:0]   o_p1_active, o_p2_active;
    logic [255:0] o_bomb_map;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    bomb_scheduler dut (
        .clk(clk), .rst(rst), .i_tick(i_tick),
        .i_p1_place(i_p1_place), .i_p2_place(i_p2_place),
        .i_p1_cor(i_p1_cor), .i_p2_cor(i_p2_cor),
        .i_p1_cap(i_p1_cap), .i_p2_cap(i_p2_cap),
        .i_p1_len(i_p1_len), .i_p2_len(i_p2_len),
        .i_explode(i_explode),
        .o_p1_ack(o_p1_ack), .o_p2_ack(o_p2_ack),
        .o_exp_valid(o_exp_valid), .o_exp_cor(o_exp_cor),
        .o_exp_len(o_exp_len), .o_exp_owner(o_exp_owner),
        .i_exp_ready(i_exp_ready),
        .o_p1_active(o_p1_active), .o_p2_active(o_p2_active),
        .o_bomb_map(o_bomb_map)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_tick      = 1'b0;
        i_p1_place  = 1'b0;
        i_p2_place  = 1'b0;
        i_p1_cor    = '0;
        i_p2_cor    = '0;
        i_p1_len    = '0;
        i_p2_len    = '0;
        i_explode   = '0;
        i_exp_ready = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    function automatic logic [255:0] exp_tuple(input logic v, input logic [7:0] c,
                                               input logic [1:0] l, input logic o);
        return 256'({v, c, l, o});
    endfunction

    function automatic logic [255:0] got_tuple();
        return 256'({o_exp_valid, o_exp_cor, o_exp_len, o_exp_owner});
    endfunction

    initial begin
        i_p1_cap = 3'd0;
        i_p2_cap = 3'd0;
        do_reset();
        check("rst_valid", 256'(o_exp_valid), 256'(0));
        check("rst_tuple", got_tuple(), exp_tuple(1'b0, 8'd0, 2'd0, 1'b0));
        check("rst_map", o_bomb_map, 256'(0));
        check("rst_active", 256'({o_p1_active, o_p2_active}), 256'(0));

        // single placement, cap limit, cap=0
        i_p1_cap = 3'd1;
        i_p2_cap = 3'd0;
        i_p1_place = 1'b1; i_p1_cor = 8'd17; i_p1_len = 2'd2;
        i_p2_place = 1'b1; i_p2_cor = 8'd40;
        cyc();
        clear_inputs();
        check("place17_ack", 256'(o_p1_ack), 256'(1));
        check("cap0_ack", 256'(o_p2_ack), 256'(0));
        check("place17_active", 256'(o_p1_active), 256'(1));
        check("place17_map", o_bomb_map, 256'(1) << 17);
        i_p1_place = 1'b1; i_p1_cor = 8'd18;
        cyc();
        clear_inputs();
        check("cap_full_ack", 256'(o_p1_ack), 256'(0));
        check("cap_full_map", o_bomb_map, 256'(1) << 17);

        // fuse expiry after 40 ticks
        for (int k = 0; k < 39; k++) begin
            i_tick = 1'b1; cyc();
            i_tick = 1'b0; cyc();
        end
        check("fuse39_valid", 256'(o_exp_valid), 256'(0));
        i_tick = 1'b1; cyc();
        i_tick = 1'b0; cyc();
        check("fuse40_tuple", got_tuple(), exp_tuple(1'b1, 8'd17, 2'd2, 1'b0));
        for (int k = 0; k < 5; k++) begin
            i_tick = k[0];
            cyc();
            check("hold_tuple", got_tuple(), exp_tuple(1'b1, 8'd17, 2'd2, 1'b0));
        end
        i_tick = 1'b0;
        i_exp_ready = 1'b1;
        cyc();
        i_exp_ready = 1'b0;
        check("hs17_valid", 256'(o_exp_valid), 256'(0));
        check("hs17_active", 256'(o_p1_active), 256'(0));
        check("hs17_map", o_bomb_map, 256'(0));

        // same-cell conflict: round robin
        do_reset();
        i_p1_cap = 3'd2;
        i_p2_cap = 3'd2;
        i_p1_place = 1'b1; i_p1_cor = 8'd50;
        i_p2_place = 1'b1; i_p2_cor = 8'd50;
        cyc();
        clear_inputs();
        check("rr50_acks", 256'({o_p1_ack, o_p2_ack}), 256'(2'b10));
        i_p1_place = 1'b1; i_p1_cor = 8'd60;
        i_p2_place = 1'b1; i_p2_cor = 8'd60;
        cyc();
        clear_inputs();
        check("rr60_acks", 256'({o_p1_ack, o_p2_ack}), 256'(2'b01));
        check("rr_active", 256'({o_p1_active, o_p2_active}), 256'({3'd1, 3'd1}));

        // chain detonation while presenting
        do_reset();
        i_p1_place = 1'b1; i_p1_cor = 8'd20; i_p1_len = 2'd1;
        i_p2_place = 1'b1; i_p2_cor = 8'd21; i_p2_len = 2'd3;
        cyc();
        clear_inputs();
        check("chain_acks", 256'({o_p1_ack, o_p2_ack}), 256'(2'b11));
        i_explode[20] = 1'b1;
        cyc();
        i_explode = '0;
        cyc();
        check("chain_p20", got_tuple(), exp_tuple(1'b1, 8'd20, 2'd1, 1'b0));
        i_explode[21] = 1'b1;
        cyc();
        i_explode = '0;
        check("chain_hold20", got_tuple(), exp_tuple(1'b1, 8'd20, 2'd1, 1'b0));
        i_exp_ready = 1'b1;
        cyc();
        i_exp_ready = 1'b0;
        check("chain_hs20_valid", 256'(o_exp_valid), 256'(0));
        check("chain_hs20_map", o_bomb_map, 256'(1) << 21);
        cyc();
        check("chain_p21", got_tuple(), exp_tuple(1'b1, 8'd21, 2'd3, 1'b1));
        i_exp_ready = 1'b1;
        cyc();
        i_exp_ready = 1'b0;
        check("chain_hs21_active", 256'({o_p1_active, o_p2_active}), 256'(0));

        // full pool
        do_reset();
        i_p1_cap = 3'd7;
        i_p2_cap = 3'd7;
        for (int k = 0; k < 4; k++) begin
            i_p1_place = 1'b1; i_p1_cor = 8'(100 + 2 * k);
            i_p2_place = 1'b1; i_p2_cor = 8'(101 + 2 * k);
            cyc();
        end
        clear_inputs();
        check("full_active", 256'({o_p1_active, o_p2_active}), 256'({3'd4, 3'd4}));
        check("full_map", o_bomb_map, 256'(8'hFF) << 100);
        i_p1_place = 1'b1; i_p1_cor = 8'd200;
        cyc();
        clear_inputs();
        check("full_reject", 256'(o_p1_ack), 256'(0));
        i_explode[101] = 1'b1;
        cyc();
        i_explode = '0;
        cyc();
        check("full_p101", got_tuple(), exp_tuple(1'b1, 8'd101, 2'd0, 1'b1));
        i_exp_ready = 1'b1;
        i_p1_place = 1'b1; i_p1_cor = 8'd201;
        cyc();
        clear_inputs();
        check("full_hs_same_cycle", 256'(o_p1_ack), 256'(0));
        i_p1_place = 1'b1; i_p1_cor = 8'd201;
        cyc();
        clear_inputs();
        check("full_reuse_ack", 256'(o_p1_ack), 256'(1));
        check("full_reuse_active", 256'({o_p1_active, o_p2_active}), 256'({3'd5, 3'd3}));
        check("full_reuse_map", o_bomb_map, (256'(8'hFD) << 100) | (256'(1) << 201));

        // reset while presenting
        do_reset();
        i_p1_cap = 3'd2;
        i_p2_cap = 3'd2;
        i_p1_place = 1'b1; i_p1_cor = 8'd30;
        i_p2_place = 1'b1; i_p2_cor = 8'd32;
        cyc();
        clear_inputs();
        i_p1_place = 1'b1; i_p1_cor = 8'd31;
        cyc();
        clear_inputs();
        i_explode[30] = 1'b1;
        cyc();
        i_explode = '0;
        cyc();
        check("pre_rst_valid", 256'(o_exp_valid), 256'(1));
        check("pre_rst_active", 256'({o_p1_active, o_p2_active}), 256'({3'd2, 3'd1}));
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("post_rst_tuple", got_tuple(), exp_tuple(1'b0, 8'd0, 2'd0, 1'b0));
        check("post_rst_map", o_bomb_map, 256'(0));
        check("post_rst_active", 256'({o_p1_active, o_p2_active}), 256'(0));
        check("post_rst_acks", 256'({o_p1_ack, o_p2_ack}), 256'(0));
        cyc();
        cyc();
        check("post_rst_discard", 256'(o_exp_valid), 256'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
